noise_gate_core: RTL and testbench

NOISE_GATE_CORE -- requirements
Module: noise_gate_core

---
 rtl/noise_gate_core.sv | 151 +++++++++++++++
 tb/tb_noise_gate_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/noise_gate_core.sv
`default_nettype none
// ============================================================================
// Module   : noise_gate_core
// Function : stereo noise gate - peak envelope follower, five-state gain FSM
//            and per-channel gain multiply, one update per VALID strobe.
// Revision : 1.0
// ============================================================================
module noise_gate_core (
   input  logic        clk,
   input  logic        RESET,
   input  logic        VALID,
   input  logic [15:0] left_in,
   input  logic [15:0] right_in,
   input  logic [11:0] thresh_slider,
   input  logic [11:0] hold_slider,
   output logic [15:0] left_out,
   output logic [15:0] right_out,
   output logic        out_vld,
   output logic        gate_open
);

   typedef enum logic [2:0] {
      ST_CLOSED  = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_OPEN    = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   localparam logic [7:0] c_GAIN_UNITY = 8'd128;
   localparam logic [7:0] c_GAIN_STEP  = 8'd8;

   state_t             r_state;
   state_t             w_state_next;
   logic [7:0]         r_gain;
   logic [7:0]         w_gain_next;
   logic [7:0]         w_gain_up;
   logic [14:0]        r_env;
   logic [14:0]        w_env_next;
   logic [14:0]        w_mag_l;
   logic [14:0]        w_mag_r;
   logic [14:0]        w_mag;
   logic [14:0]        w_thresh;
   logic [15:0]        r_hold_cnt;
   logic [15:0]        w_hold_next;
   logic               w_above;
   logic signed [24:0] w_prod_l;
   logic signed [24:0] w_prod_r;
   logic               w_unused;

   // |-32768| has no 15-bit representation, so it clips to full scale
   function automatic logic [14:0] f_abs_sat(input logic [15:0] s);
      if (s == 16'h8000)
         return 15'h7FFF;
      else if (s[15])
         return ~s[14:0] + 15'd1;
      else
         return s[14:0];
   endfunction

   assign w_mag_l    = f_abs_sat(left_in);
   assign w_mag_r    = f_abs_sat(right_in);
   assign w_mag      = (w_mag_l > w_mag_r) ? w_mag_l : w_mag_r;
   assign w_env_next = (w_mag > r_env) ? w_mag : (r_env - (r_env >> 8));
   assign w_thresh   = {thresh_slider, 3'b000};
   assign w_above    = (w_env_next >= w_thresh);
   assign w_gain_up  = (r_gain >= (c_GAIN_UNITY - c_GAIN_STEP)) ? c_GAIN_UNITY
                                                                : (r_gain + c_GAIN_STEP);

   always_comb begin
      w_state_next = r_state;
      w_gain_next  = r_gain;
      w_hold_next  = r_hold_cnt;
      case (r_state)
         ST_CLOSED: begin
            w_gain_next = 8'd0;
            if (w_above) begin
               w_state_next = ST_ATTACK;
               w_gain_next  = c_GAIN_STEP;
            end
         end
         ST_ATTACK: begin
            w_gain_next = w_gain_up;
            if (w_gain_up == c_GAIN_UNITY)
               w_state_next = ST_OPEN;
         end
         ST_OPEN: begin
            w_gain_next = c_GAIN_UNITY;
            if (!w_above) begin
               w_state_next = ST_HOLD;
               w_hold_next  = {hold_slider, 4'b0000};
            end
         end
         ST_HOLD: begin
            if (w_above)
               w_state_next = ST_OPEN;
            else if (r_hold_cnt == 16'd0)
               w_state_next = ST_RELEASE;
            else
               w_hold_next = r_hold_cnt - 16'd1;
         end
         ST_RELEASE: begin
            if (w_above) begin
               w_state_next = ST_ATTACK;
               w_gain_next  = w_gain_up;
            end else if (r_gain <= 8'd1) begin
               w_state_next = ST_CLOSED;
               w_gain_next  = 8'd0;
            end else begin
               w_gain_next = r_gain - 8'd1;
            end
         end
         default: begin
            w_state_next = ST_CLOSED;
            w_gain_next  = 8'd0;
            w_hold_next  = 16'd0;
         end
      endcase
   end

   // Product bits [22:7] are the arithmetic >>>7 result truncated to 16 bits
   assign w_prod_l = $signed({{9{left_in[15]}}, left_in})   * $signed({17'd0, w_gain_next});
   assign w_prod_r = $signed({{9{right_in[15]}}, right_in}) * $signed({17'd0, w_gain_next});
   assign w_unused = ^{w_prod_l[24:23], w_prod_l[6:0], w_prod_r[24:23], w_prod_r[6:0]};

   always_ff @(posedge clk) begin
      if (RESET) begin
         r_state    <= ST_CLOSED;
         r_gain     <= 8'd0;
         r_env      <= 15'd0;
         r_hold_cnt <= 16'd0;
         left_out   <= 16'd0;
         right_out  <= 16'd0;
         out_vld    <= 1'b0;
         gate_open  <= 1'b0;
      end else begin
         out_vld <= VALID;
         if (VALID) begin
            r_state    <= w_state_next;
            r_gain     <= w_gain_next;
            r_env      <= w_env_next;
            r_hold_cnt <= w_hold_next;
            left_out   <= w_prod_l[22:7];
            right_out  <= w_prod_r[22:7];
            gate_open  <= (w_gain_next != 8'd0);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_noise_gate_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_noise_gate_core
// Function : directed scoreboard bench for noise_gate_core.
// Revision : 1.0
// ============================================================================
module tb_noise_gate_core;

   logic        clk           = 1'b0;
   logic        RESET         = 1'b1;
   logic        VALID         = 1'b0;
   logic [15:0] left_in       = '0;
   logic [15:0] right_in      = '0;
   logic [11:0] thresh_slider = '0;
   logic [11:0] hold_slider   = '0;
   logic [15:0] left_out;
   logic [15:0] right_out;
   logic        out_vld;
   logic        gate_open;

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
      logic        g;
   } exp_t;

   exp_t        q[$];
   int          n_checks   = 0;
   int          n_pass     = 0;
   int          env_m      = 0;
   logic        prev_valid = 1'b0;
   logic        prev_rst   = 1'b1;
   logic [15:0] last_l     = '0;
   logic [15:0] last_r     = '0;
   logic        last_g     = 1'b0;

   noise_gate_core dut (
      .clk           (clk),
      .RESET         (RESET),
      .VALID         (VALID),
      .left_in       (left_in),
      .right_in      (right_in),
      .thresh_slider (thresh_slider),
      .hold_slider   (hold_slider),
      .left_out      (left_out),
      .right_out     (right_out),
      .out_vld       (out_vld),
      .gate_open     (gate_open)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act == exp_v)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
   endtask

   function automatic int f_mag(input int l, input int r);
      int a;
      int b;
      a = (l < 0) ? -l : l;
      b = (r < 0) ? -r : r;
      if (a > 32767) a = 32767;
      if (b > 32767) b = 32767;
      return (a > b) ? a : b;
   endfunction

   function automatic int f_env(input int e, input int m);
      return (m > e) ? m : (e - (e >> 8));
   endfunction

   function automatic logic [15:0] f_scale(input int s, input int g);
      int p;
      p = (s * g) >>> 7;
      return p[15:0];
   endfunction

   task automatic send(input int l, input int r, input int ts, input int hs, input int g);
      exp_t e;
      VALID         = 1'b1;
      left_in       = 16'(l);
      right_in      = 16'(r);
      thresh_slider = 12'(ts);
      hold_slider   = 12'(hs);
      e.l = f_scale(l, g);
      e.r = f_scale(r, g);
      e.g = (g != 0);
      q.push_back(e);
      env_m = f_env(env_m, f_mag(l, r));
      @(posedge clk);
      #1;
      VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         thresh_slider = 12'hFFF;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      VALID = 1'b0;
      @(posedge clk);
      #1;
      RESET = 1'b0;
      env_m = 0;
   endtask

   // Quiet probe (R=128, below threshold) makes right_out equal the gain
   task automatic decay_to_hold(input int ts, input int hs);
      int guard;
      guard = 0;
      while (f_env(env_m, 128) >= 8 * ts && guard < 4000) begin
         send(0, 128, ts, hs, 128);
         guard++;
      end
      if (guard >= 4000) begin
         n_checks++;
         $display("FAIL decay_bound: got %0d steps, expected fewer than 4000", guard);
      end
      send(0, 128, ts, hs, 128);
   endtask

   always @(posedge clk) begin
      prev_valid <= VALID;
      prev_rst   <= RESET;
   end

   always @(negedge clk) begin
      exp_t e;
      if (prev_rst) begin
         check("rst_out_vld", int'(out_vld), 0);
         check("rst_left",    int'($signed(left_out)), 0);
         check("rst_right",   int'($signed(right_out)), 0);
         check("rst_gate",    int'(gate_open), 0);
         last_l = '0;
         last_r = '0;
         last_g = 1'b0;
      end else if (out_vld) begin
         check("out_vld_latency", int'(prev_valid), 1);
         if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            e = q.pop_front();
            check("left_out",  int'($signed(left_out)),  int'($signed(e.l)));
            check("right_out", int'($signed(right_out)), int'($signed(e.r)));
            check("gate_open", int'(gate_open), int'(e.g));
            last_l = e.l;
            last_r = e.r;
            last_g = e.g;
         end
      end else begin
         check("out_vld_missing", 0, int'(prev_valid));
         if (prev_valid && q.size() != 0) void'(q.pop_front());
         check("hold_left",  int'($signed(left_out)),  int'($signed(last_l)));
         check("hold_right", int'($signed(right_out)), int'($signed(last_r)));
         check("hold_gate",  int'(gate_open), int'(last_g));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Sub-threshold input keeps the gate closed
      do_reset();
      repeat (20) send(100, 100, 100, 0, 0);

      // Attack ramp 8..128 with idle gaps and slider noise between strobes
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         send(4000, 4000, 100, 0, 8 * k);
         if (k == 4 || k == 9) idle(3);
      end
      send(4000, 4000, 100, 0, 128);

      // OPEN -> HOLD (16) -> RELEASE ramp to 0
      decay_to_hold(100, 1);
      repeat (16) send(0, 128, 100, 1, 128);
      send(0, 128, 100, 1, 128);
      for (int g = 127; g >= 0; g--) send(0, 128, 100, 1, g);
      idle(2);

      // Zero hold, release down to 60, then re-attack from 68
      do_reset();
      for (int k = 1; k <= 16; k++) send(4000, 4000, 100, 0, 8 * k);
      decay_to_hold(100, 0);
      send(0, 128, 100, 0, 128);
      for (int g = 127; g >= 60; g--) send(0, 128, 100, 0, g);
      for (int g = 68; g <= 124; g += 8) send(4000, 4000, 100, 0, g);
      send(4000, 4000, 100, 0, 128);
      send(4000, 4000, 100, 0, 128);

      // Zero threshold opens at once; full-scale negative passes at unity
      do_reset();
      for (int k = 1; k <= 16; k++) send(0, 0, 0, 0, 8 * k);
      repeat (3) send(-32768, 32767, 4000, 0, 128);

      // Reset coincident with VALID mid-attack discards the sample
      do_reset();
      for (int k = 1; k <= 5; k++) send(4000, 4000, 100, 0, 8 * k);
      VALID    = 1'b1;
      RESET    = 1'b1;
      left_in  = 16'd4000;
      right_in = 16'd4000;
      @(posedge clk);
      #1;
      VALID = 1'b0;
      RESET = 1'b0;
      env_m = 0;
      idle(2);
      send(4000, 4000, 100, 0, 8);
      send(4000, 4000, 100, 0, 16);

      idle(3);
      check("queue_drain", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
